decode_stage: RTL and testbench

Instruction-decode stage of the five-stage MIPS pipeline; consumes the IF/ID pipeline register produced by the fetch stage and drives the ID/EX pipeline register. Owns the 32×32 register file, main control decode, sign extension, load-use hazard detection, and early (ID-stage) resolution of beq/bne/j. Returns the branch target, PC-select, stall and flush signals to fetch.

---
 rtl/mips_pkg.sv | 80 ++++++++
 rtl/decode_stage_if.sv | 24 ++
 rtl/decode_stage_reg_file.sv | 47 ++++
 rtl/decode_stage.sv | 124 ++++++++++++
 tb/tb_decode_stage.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared widths, opcodes and control-word layout for the MIPS decode stage.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int NREGS  = 32;
    localparam int CTRL_W = 9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Field order matches the 9-bit IDEXctrl bus, MSB first.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t             ctrl;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [5:0]        funct;
        logic [DATA_W-1:0] pc4;
    } idex_t;

    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            OP_BEQ, OP_BNE: begin
                c.branch = 1'b1;
                c.alu_op = ALUOP_SUB;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ID/EX pipeline register bundle: decode drives it, execute consumes it.
interface decode_stage_if;
    import mips_pkg::*;

    logic [CTRL_W-1:0] IDEXctrl;
    logic [DATA_W-1:0] IDEXreadData1;
    logic [DATA_W-1:0] IDEXreadData2;
    logic [DATA_W-1:0] IDEXimmediate;
    logic [REG_W-1:0]  IDEXrs;
    logic [REG_W-1:0]  IDEXrt;
    logic [REG_W-1:0]  IDEXrd;
    logic [5:0]        IDEXfunct;
    logic [DATA_W-1:0] IDEXpcplusfour;

    modport master (
        output IDEXctrl, IDEXreadData1, IDEXreadData2, IDEXimmediate,
               IDEXrs, IDEXrt, IDEXrd, IDEXfunct, IDEXpcplusfour
    );

    modport slave (
        input IDEXctrl, IDEXreadData1, IDEXreadData2, IDEXimmediate,
              IDEXrs, IDEXrt, IDEXrd, IDEXfunct, IDEXpcplusfour
    );
endinterface

// File: rtl/decode_stage_reg_file.sv
// 32x32 register file: two async read ports, one sync write port, $0 hardwired,
// same-cycle writeback forwarded to the read ports.
module reg_file
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  raddr1_i,
    input  logic [REG_W-1:0]  raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              we_i,
    input  logic [REG_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] rf_q [NREGS];
    logic              wr_live;

    assign wr_live = we_i && (waddr_i != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_live) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = rf_q[raddr1_i];
        rdata2_o = rf_q[raddr2_i];
        if (raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (wr_live && waddr_i == raddr1_i) begin
            rdata1_o = wdata_i;
        end
        if (raddr2_i == '0) begin
            rdata2_o = '0;
        end else if (wr_live && waddr_i == raddr2_i) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: control decode, register file, hazard detection, early
// beq/bne/j resolution and the ID/EX pipeline register.
module decode_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] IFIDinstruction,
    input  logic [DATA_W-1:0] IFIDpcplusfour,
    input  logic              wbRegWrite,
    input  logic [REG_W-1:0]  wbWriteReg,
    input  logic [DATA_W-1:0] wbWriteData,
    input  logic              IDEXMemReadIn,
    input  logic              IDEXRegWriteIn,
    input  logic [REG_W-1:0]  IDEXDestIn,
    input  logic              EXMEMRegWrite,
    input  logic [REG_W-1:0]  EXMEMRd,
    output logic [DATA_W-1:0] BranchAdress,
    output logic              muxCtrl,
    output logic              stall,
    output logic              flush,
    decode_stage_if.master    idex
);

    logic [5:0]               opcode;
    logic [REG_W-1:0]         rs, rt, rd;
    logic signed [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0]        rs_val, rt_val;
    logic [DATA_W-1:0]        br_target, jmp_target;
    logic                     is_cond_br, is_jump;
    logic                     hit_ex, hit_mem, load_use, br_hazard, stall_raw, taken;
    idex_t                    idex_d, idex_q;

    assign opcode  = IFIDinstruction[31:26];
    assign rs      = IFIDinstruction[25:21];
    assign rt      = IFIDinstruction[20:16];
    assign rd      = IFIDinstruction[15:11];
    assign imm_ext = {{16{IFIDinstruction[15]}}, IFIDinstruction[15:0]};

    reg_file u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (rs_val),
        .rdata2_o (rt_val),
        .we_i     (wbRegWrite),
        .waddr_i  (wbWriteReg),
        .wdata_i  (wbWriteData)
    );

    assign is_cond_br = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_jump    = (opcode == OP_J);
    assign br_target  = IFIDpcplusfour + {imm_ext[DATA_W-3:0], 2'b00};
    assign jmp_target = {IFIDpcplusfour[31:28], IFIDinstruction[25:0], 2'b00};

    // Branches compare in ID, so any pending producer in EX or MEM must drain first.
    always_comb begin
        hit_ex    = (IDEXDestIn != '0) && ((IDEXDestIn == rs) || (IDEXDestIn == rt));
        hit_mem   = (EXMEMRd != '0) && ((EXMEMRd == rs) || (EXMEMRd == rt));
        load_use  = IDEXMemReadIn && hit_ex;
        br_hazard = is_cond_br && ((IDEXRegWriteIn && hit_ex) || (EXMEMRegWrite && hit_mem));
        stall_raw = load_use || br_hazard;
        taken     = 1'b0;
        if (!stall_raw) begin
            case (opcode)
                OP_BEQ:  taken = (rs_val == rt_val);
                OP_BNE:  taken = (rs_val != rt_val);
                OP_J:    taken = 1'b1;
                default: taken = 1'b0;
            endcase
        end
    end

    assign stall   = rst_n && stall_raw;
    assign muxCtrl = rst_n && taken;
    assign flush   = rst_n && taken;

    always_comb begin
        BranchAdress = '0;
        if (rst_n) begin
            if (taken) begin
                BranchAdress = is_jump ? jmp_target : br_target;
            end else begin
                BranchAdress = IFIDpcplusfour;
            end
        end
    end

    always_comb begin
        idex_d = '0;
        if (!stall_raw) begin
            idex_d.ctrl  = decode_ctrl(opcode);
            idex_d.rd1   = rs_val;
            idex_d.rd2   = rt_val;
            idex_d.imm   = imm_ext;
            idex_d.rs    = rs;
            idex_d.rt    = rt;
            idex_d.rd    = rd;
            idex_d.funct = IFIDinstruction[5:0];
            idex_d.pc4   = IFIDpcplusfour;
        end
    end

    // ID/EX boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign idex.IDEXctrl       = idex_q.ctrl;
    assign idex.IDEXreadData1  = idex_q.rd1;
    assign idex.IDEXreadData2  = idex_q.rd2;
    assign idex.IDEXimmediate  = idex_q.imm;
    assign idex.IDEXrs         = idex_q.rs;
    assign idex.IDEXrt         = idex_q.rt;
    assign idex.IDEXrd         = idex_q.rd;
    assign idex.IDEXfunct      = idex_q.funct;
    assign idex.IDEXpcplusfour = idex_q.pc4;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// cycles compared against a behavioural model of the ID stage.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] IFIDinstruction, IFIDpcplusfour;
    logic        wbRegWrite;
    logic [4:0]  wbWriteReg;
    logic [31:0] wbWriteData;
    logic        IDEXMemReadIn, IDEXRegWriteIn;
    logic [4:0]  IDEXDestIn;
    logic        EXMEMRegWrite;
    logic [4:0]  EXMEMRd;
    logic [31:0] BranchAdress;
    logic        muxCtrl, stall, flush;

    decode_stage_if idex_bus();

    decode_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .IFIDinstruction (IFIDinstruction),
        .IFIDpcplusfour  (IFIDpcplusfour),
        .wbRegWrite      (wbRegWrite),
        .wbWriteReg      (wbWriteReg),
        .wbWriteData     (wbWriteData),
        .IDEXMemReadIn   (IDEXMemReadIn),
        .IDEXRegWriteIn  (IDEXRegWriteIn),
        .IDEXDestIn      (IDEXDestIn),
        .EXMEMRegWrite   (EXMEMRegWrite),
        .EXMEMRd         (EXMEMRd),
        .BranchAdress    (BranchAdress),
        .muxCtrl         (muxCtrl),
        .stall           (stall),
        .flush           (flush),
        .idex            (idex_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] mrf [32];
    logic [31:0] e_ba;
    logic        e_mux, e_stall, e_flush;
    logic [31:0] s_ba;
    logic        s_mux, s_stall, s_flush;
    logic [8:0]  n_ctrl;
    logic [31:0] n_rd1, n_rd2, n_imm, n_pc4;
    logic [4:0]  n_rs, n_rt, n_rd;
    logic [5:0]  n_funct;

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] f);
        return {6'h00, s, t, d, 5'h00, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    // Control word written out directly from the opcode table.
    function automatic logic [8:0] mctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b100100010;
            6'h23:   return 9'b011110000;
            6'h2B:   return 9'b010001000;
            6'h08:   return 9'b010100000;
            6'h04:   return 9'b000000101;
            6'h05:   return 9'b000000101;
            default: return 9'b000000000;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wbRegWrite && wbWriteReg == a) return wbWriteData;
        return mrf[a];
    endfunction

    task automatic model_eval();
        logic [5:0]  op;
        logic [4:0]  s, t;
        logic [31:0] v1, v2, sx, tgt;
        logic        in_ex, in_mem, lu, bh, tk;
        op     = IFIDinstruction[31:26];
        s      = IFIDinstruction[25:21];
        t      = IFIDinstruction[20:16];
        v1     = mread(s);
        v2     = mread(t);
        sx     = {{16{IFIDinstruction[15]}}, IFIDinstruction[15:0]};
        in_ex  = (IDEXDestIn != 0) && (IDEXDestIn == s || IDEXDestIn == t);
        in_mem = (EXMEMRd != 0) && (EXMEMRd == s || EXMEMRd == t);
        lu     = IDEXMemReadIn && in_ex;
        bh     = (op == 6'h04 || op == 6'h05) &&
                 ((IDEXRegWriteIn && in_ex) || (EXMEMRegWrite && in_mem));
        e_stall = rst_n && (lu || bh);
        tk      = rst_n && !e_stall &&
                  ((op == 6'h04 && v1 == v2) || (op == 6'h05 && v1 != v2) || op == 6'h02);
        tgt     = (op == 6'h02) ? {IFIDpcplusfour[31:28], IFIDinstruction[25:0], 2'b00}
                                : IFIDpcplusfour + sx * 4;
        e_mux   = tk;
        e_flush = tk;
        e_ba    = !rst_n ? 32'h0 : (tk ? tgt : IFIDpcplusfour);
        if (!rst_n || e_stall) begin
            n_ctrl = '0; n_rd1 = '0; n_rd2 = '0; n_imm = '0; n_pc4 = '0;
            n_rs = '0; n_rt = '0; n_rd = '0; n_funct = '0;
        end else begin
            n_ctrl = mctrl(op); n_rd1 = v1; n_rd2 = v2; n_imm = sx; n_pc4 = IFIDpcplusfour;
            n_rs = s; n_rt = t; n_rd = IFIDinstruction[15:11]; n_funct = IFIDinstruction[5:0];
        end
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        end else if (wbRegWrite && wbWriteReg != 0) begin
            mrf[wbWriteReg] = wbWriteData;
        end
    endtask

    // Settle, capture combinational outputs, clock once, then let registers settle.
    task automatic step();
        #1;
        model_eval();
        s_ba = BranchAdress; s_mux = muxCtrl; s_stall = stall; s_flush = flush;
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic quiet();
        IFIDinstruction = 32'h0; IFIDpcplusfour = 32'h0;
        wbRegWrite = 1'b0; wbWriteReg = 5'd0; wbWriteData = 32'h0;
        IDEXMemReadIn = 1'b0; IDEXRegWriteIn = 1'b0; IDEXDestIn = 5'd0;
        EXMEMRegWrite = 1'b0; EXMEMRd = 5'd0;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
        quiet();
        wbRegWrite = 1'b1; wbWriteReg = r; wbWriteData = v;
        step();
        wbRegWrite = 1'b0;
    endtask

    task automatic test_reset();
        quiet();
        rst_n = 1'b0;
        IFIDinstruction = {6'h02, 26'h0000010};
        IFIDpcplusfour  = 32'h10000004;
        step();
        step();
        checks++; if (s_mux !== 1'b0 || s_flush !== 1'b0 || s_stall !== 1'b0) begin
            errors++; $display("FAIL reset_comb got mux=%b flush=%b stall=%b want 0", s_mux, s_flush, s_stall);
        end
        checks++; if (s_ba !== 32'h0) begin
            errors++; $display("FAIL reset_ba got %h want 0", s_ba);
        end
        checks++; if (idex_bus.IDEXctrl !== 9'h0 || idex_bus.IDEXpcplusfour !== 32'h0 ||
                      idex_bus.IDEXimmediate !== 32'h0 || idex_bus.IDEXrs !== 5'h0) begin
            errors++; $display("FAIL reset_idex got ctrl=%h pc4=%h want 0", idex_bus.IDEXctrl, idex_bus.IDEXpcplusfour);
        end
        rst_n = 1'b1;
        quiet();
        IFIDinstruction = rtype(5'd5, 5'd6, 5'd3, 6'h20);
        step();
        checks++; if (idex_bus.IDEXreadData1 !== 32'h0 || idex_bus.IDEXreadData2 !== 32'h0) begin
            errors++; $display("FAIL reset_regs got %h %h want 0", idex_bus.IDEXreadData1, idex_bus.IDEXreadData2);
        end
    endtask

    task automatic test_add();
        wb_write(5'd5, 32'd7);
        quiet();
        IFIDinstruction = rtype(5'd5, 5'd5, 5'd3, 6'h20);
        IFIDpcplusfour  = 32'h24;
        step();
        checks++; if (idex_bus.IDEXreadData1 !== 32'd7 || idex_bus.IDEXreadData2 !== 32'd7) begin
            errors++; $display("FAIL add_data got %0d %0d want 7 7", idex_bus.IDEXreadData1, idex_bus.IDEXreadData2);
        end
        checks++; if (idex_bus.IDEXctrl !== 9'b100100010 || idex_bus.IDEXrd !== 5'd3 ||
                      idex_bus.IDEXfunct !== 6'h20 || idex_bus.IDEXpcplusfour !== 32'h24) begin
            errors++; $display("FAIL add_ctrl got ctrl=%b rd=%0d want 100100010 rd=3", idex_bus.IDEXctrl, idex_bus.IDEXrd);
        end
    endtask

    task automatic test_load_use();
        quiet();
        IDEXMemReadIn = 1'b1; IDEXRegWriteIn = 1'b1; IDEXDestIn = 5'd4;
        IFIDinstruction = rtype(5'd4, 5'd1, 5'd2, 6'h20);
        IFIDpcplusfour  = 32'h80;
        step();
        checks++; if (s_stall !== 1'b1 || s_mux !== 1'b0 || s_flush !== 1'b0) begin
            errors++; $display("FAIL loaduse_stall got stall=%b mux=%b flush=%b want 1 0 0", s_stall, s_mux, s_flush);
        end
        checks++; if (idex_bus.IDEXctrl !== 9'h0 || idex_bus.IDEXrs !== 5'd0 || idex_bus.IDEXpcplusfour !== 32'h0) begin
            errors++; $display("FAIL loaduse_bubble got ctrl=%h rs=%0d pc4=%h want 0", idex_bus.IDEXctrl, idex_bus.IDEXrs, idex_bus.IDEXpcplusfour);
        end
        IDEXMemReadIn = 1'b0; IDEXRegWriteIn = 1'b0; IDEXDestIn = 5'd0;
        EXMEMRegWrite = 1'b1; EXMEMRd = 5'd4;
        step();
        checks++; if (s_stall !== 1'b0) begin
            errors++; $display("FAIL loaduse_release got stall=%b want 0", s_stall);
        end
        checks++; if (idex_bus.IDEXctrl !== 9'b100100010 || idex_bus.IDEXrs !== 5'd4 || idex_bus.IDEXrt !== 5'd1) begin
            errors++; $display("FAIL loaduse_issue got ctrl=%b rs=%0d want 100100010 rs=4", idex_bus.IDEXctrl, idex_bus.IDEXrs);
        end
    endtask

    task automatic test_branch();
        wb_write(5'd1, 32'd9);
        wb_write(5'd2, 32'd9);
        quiet();
        IFIDinstruction = itype(6'h04, 5'd1, 5'd2, 16'd3);
        IFIDpcplusfour  = 32'h40;
        step();
        checks++; if (s_mux !== 1'b1 || s_flush !== 1'b1 || s_ba !== 32'h4C) begin
            errors++; $display("FAIL beq_taken got mux=%b flush=%b ba=%h want 1 1 4c", s_mux, s_flush, s_ba);
        end
        checks++; if (idex_bus.IDEXctrl !== 9'b000000101 || idex_bus.IDEXimmediate !== 32'd3) begin
            errors++; $display("FAIL beq_idex got ctrl=%b imm=%h want 000000101 3", idex_bus.IDEXctrl, idex_bus.IDEXimmediate);
        end
        wb_write(5'd2, 32'd8);
        quiet();
        IFIDinstruction = itype(6'h04, 5'd1, 5'd2, 16'd3);
        IFIDpcplusfour  = 32'h40;
        step();
        checks++; if (s_mux !== 1'b0 || s_flush !== 1'b0 || s_ba !== 32'h40) begin
            errors++; $display("FAIL beq_not_taken got mux=%b flush=%b ba=%h want 0 0 40", s_mux, s_flush, s_ba);
        end
        IFIDinstruction = itype(6'h05, 5'd1, 5'd2, 16'hFFFF);
        step();
        checks++; if (s_mux !== 1'b1 || s_ba !== 32'h3C) begin
            errors++; $display("FAIL bne_back got mux=%b ba=%h want 1 3c", s_mux, s_ba);
        end
    endtask

    task automatic test_jump();
        quiet();
        IFIDinstruction = {6'h02, 26'h0000010};
        IFIDpcplusfour  = 32'h10000004;
        step();
        checks++; if (s_mux !== 1'b1 || s_flush !== 1'b1 || s_ba !== 32'h10000040) begin
            errors++; $display("FAIL jump got mux=%b flush=%b ba=%h want 1 1 10000040", s_mux, s_flush, s_ba);
        end
        checks++; if (idex_bus.IDEXctrl !== 9'h0 || idex_bus.IDEXpcplusfour !== 32'h10000004) begin
            errors++; $display("FAIL jump_idex got ctrl=%b pc4=%h want 0 10000004", idex_bus.IDEXctrl, idex_bus.IDEXpcplusfour);
        end
    endtask

    task automatic test_exmem_bypass();
        wb_write(5'd6, 32'd5);
        wb_write(5'd7, 32'd11);
        quiet();
        IFIDinstruction = itype(6'h04, 5'd6, 5'd7, 16'hFFFE);
        IFIDpcplusfour  = 32'h200;
        EXMEMRegWrite = 1'b1; EXMEMRd = 5'd6;
        step();
        checks++; if (s_stall !== 1'b1 || s_mux !== 1'b0 || idex_bus.IDEXctrl !== 9'h0) begin
            errors++; $display("FAIL exmem_stall got stall=%b mux=%b ctrl=%h want 1 0 0", s_stall, s_mux, idex_bus.IDEXctrl);
        end
        EXMEMRegWrite = 1'b0; EXMEMRd = 5'd0;
        wbRegWrite = 1'b1; wbWriteReg = 5'd6; wbWriteData = 32'd11;
        step();
        checks++; if (s_stall !== 1'b0 || s_mux !== 1'b1 || s_ba !== 32'h1F8) begin
            errors++; $display("FAIL wb_bypass got stall=%b mux=%b ba=%h want 0 1 1f8", s_stall, s_mux, s_ba);
        end
    endtask

    task automatic test_load_branch();
        logic [2:0] st;
        quiet();
        IFIDinstruction = itype(6'h04, 5'd8, 5'd0, 16'd1);
        IFIDpcplusfour  = 32'h100;
        IDEXMemReadIn = 1'b1; IDEXRegWriteIn = 1'b1; IDEXDestIn = 5'd8;
        step();
        st[0] = s_stall;
        IDEXMemReadIn = 1'b0; IDEXRegWriteIn = 1'b0; IDEXDestIn = 5'd0;
        EXMEMRegWrite = 1'b1; EXMEMRd = 5'd8;
        step();
        st[1] = s_stall;
        EXMEMRegWrite = 1'b0; EXMEMRd = 5'd0;
        wbRegWrite = 1'b1; wbWriteReg = 5'd8; wbWriteData = 32'd0;
        step();
        st[2] = s_stall;
        checks++; if (st !== 3'b011) begin
            errors++; $display("FAIL load_branch_stalls got %b want 011", st);
        end
        checks++; if (s_mux !== 1'b1 || s_ba !== 32'h104) begin
            errors++; $display("FAIL load_branch_resolve got mux=%b ba=%h want 1 104", s_mux, s_ba);
        end
    endtask

    task automatic test_reset_mid();
        wb_write(5'd5, 32'h55);
        quiet();
        IFIDinstruction = rtype(5'd5, 5'd5, 5'd3, 6'h20);
        IFIDpcplusfour  = 32'h300;
        step();
        checks++; if (idex_bus.IDEXreadData1 !== 32'h55) begin
            errors++; $display("FAIL pre_reset_read got %h want 55", idex_bus.IDEXreadData1);
        end
        rst_n = 1'b0;
        IDEXMemReadIn = 1'b1; IDEXDestIn = 5'd5;
        step();
        checks++; if (s_stall !== 1'b0 || s_mux !== 1'b0 || s_flush !== 1'b0 || s_ba !== 32'h0) begin
            errors++; $display("FAIL midreset_comb got stall=%b mux=%b flush=%b ba=%h want 0", s_stall, s_mux, s_flush, s_ba);
        end
        checks++; if (idex_bus.IDEXctrl !== 9'h0 || idex_bus.IDEXreadData1 !== 32'h0 || idex_bus.IDEXpcplusfour !== 32'h0) begin
            errors++; $display("FAIL midreset_idex got ctrl=%h rd1=%h pc4=%h want 0", idex_bus.IDEXctrl, idex_bus.IDEXreadData1, idex_bus.IDEXpcplusfour);
        end
        rst_n = 1'b1;
        quiet();
        IFIDinstruction = rtype(5'd5, 5'd5, 5'd3, 6'h20);
        step();
        checks++; if (idex_bus.IDEXreadData1 !== 32'h0 || idex_bus.IDEXctrl !== 9'b100100010) begin
            errors++; $display("FAIL midreset_regs got rd1=%h ctrl=%b want 0 100100010", idex_bus.IDEXreadData1, idex_bus.IDEXctrl);
        end
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h08;
                4: op = 6'h04;
                5: op = 6'h05;
                6: op = 6'h02;
                default: op = 6'($urandom_range(0, 63));
            endcase
            IFIDinstruction = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            IFIDpcplusfour  = $urandom & 32'hFFFF_FFFC;
            wbRegWrite      = 1'($urandom_range(0, 1));
            wbWriteReg      = 5'($urandom_range(0, 7));
            wbWriteData     = 32'($urandom_range(0, 3));
            IDEXMemReadIn   = ($urandom_range(0, 3) == 0);
            IDEXRegWriteIn  = 1'($urandom_range(0, 1));
            IDEXDestIn      = 5'($urandom_range(0, 7));
            EXMEMRegWrite   = ($urandom_range(0, 2) == 0);
            EXMEMRd         = 5'($urandom_range(0, 7));
            rst_n           = ($urandom_range(0, 49) != 0);
            step();
            checks++; if (s_stall !== e_stall || s_mux !== e_mux || s_flush !== e_flush) begin
                errors++; $display("FAIL rnd_ctl[%0d] got stall=%b mux=%b flush=%b want %b %b %b", n, s_stall, s_mux, s_flush, e_stall, e_mux, e_flush);
            end
            checks++; if (s_ba !== e_ba) begin
                errors++; $display("FAIL rnd_ba[%0d] got %h want %h", n, s_ba, e_ba);
            end
            checks++; if (idex_bus.IDEXctrl !== n_ctrl || idex_bus.IDEXreadData1 !== n_rd1 || idex_bus.IDEXreadData2 !== n_rd2) begin
                errors++; $display("FAIL rnd_idex_a[%0d] got ctrl=%b rd1=%h rd2=%h want %b %h %h", n, idex_bus.IDEXctrl, idex_bus.IDEXreadData1, idex_bus.IDEXreadData2, n_ctrl, n_rd1, n_rd2);
            end
            checks++; if (idex_bus.IDEXimmediate !== n_imm || idex_bus.IDEXpcplusfour !== n_pc4 || idex_bus.IDEXfunct !== n_funct ||
                          idex_bus.IDEXrs !== n_rs || idex_bus.IDEXrt !== n_rt || idex_bus.IDEXrd !== n_rd) begin
                errors++; $display("FAIL rnd_idex_b[%0d] got imm=%h pc4=%h rs=%0d rt=%0d rd=%0d want %h %h %0d %0d %0d", n, idex_bus.IDEXimmediate, idex_bus.IDEXpcplusfour, idex_bus.IDEXrs, idex_bus.IDEXrt, idex_bus.IDEXrd, n_imm, n_pc4, n_rs, n_rt, n_rd);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        rst_n = 1'b0;
        quiet();
        test_reset();
        test_add();
        test_load_use();
        test_branch();
        test_jump();
        test_exmem_bypass();
        test_load_branch();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
